// File: rtl/bsg_chip_pkg.sv
// Shared link constants and types for the manycore chip link (tx credit counter and rx token generator).
package bsg_chip_pkg;

    localparam int unsigned hb_addr_width_gp   = 28;
    localparam int unsigned hb_data_width_gp   = 32;
    localparam int unsigned hb_x_cord_width_gp = 7;
    localparam int unsigned hb_y_cord_width_gp = 7;

    // Receiver buffer depth and token decimation, shared by both link directions
    localparam int unsigned link_credit_gp              = 16;
    localparam int unsigned link_lg_token_decimation_gp = 2;

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_send  = 2'd1,
        e_stall = 2'd2
    } link_tx_state_e;

    // addr + data + src/dst cords + op(2) + reg_id(5) + mask(4)
    function automatic int unsigned bsg_manycore_packet_width(
        input int unsigned addr_w,
        input int unsigned data_w,
        input int unsigned x_w,
        input int unsigned y_w
    );
        return addr_w + data_w + 2 * (x_w + y_w) + 11;
    endfunction

endpackage

// File: rtl/bsg_chip_link_credit_counter.sv
// Link credit counter: decrements on send, adds a decimated token batch, saturates at credit_p.
module bsg_chip_link_credit_counter
    import bsg_chip_pkg::*;
#(
    parameter int unsigned credit_p              = link_credit_gp,
    parameter int unsigned lg_token_decimation_p = link_lg_token_decimation_gp
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             send_i,
    input  logic                             token_i,
    output logic [$clog2(credit_p+1)-1:0]    credits_o,
    output logic [$clog2(credit_p+1)-1:0]    credits_next_c,
    output logic                             overflow_c
);

    localparam int unsigned cw        = $clog2(credit_p + 1);
    localparam int unsigned token_amt = 1 << lg_token_decimation_p;
    // One spare bit so the unsaturated sum can never wrap
    localparam int unsigned sw        = $clog2(credit_p + token_amt + 1) + 1;

    logic [sw-1:0] full_next;

    always_comb begin
        full_next      = sw'(credits_o) - sw'(send_i) + (token_i ? sw'(token_amt) : sw'(0));
        overflow_c     = (full_next > sw'(credit_p));
        credits_next_c = overflow_c ? cw'(credit_p) : cw'(full_next);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credits_o <= cw'(credit_p);
        end else begin
            credits_o <= credits_next_c;
        end
    end

endmodule

// File: rtl/bsg_chip_mc_link_credit_tx.sv
// Credit-based manycore link transmitter: registered link output, credit counter and IDLE/SEND/STALL FSM.
// Optional BSG_CHIP_LINK_CREDIT_CHECK_EN enables the sticky credit_err_o flag and credit assertions.
module bsg_chip_mc_link_credit_tx
    import bsg_chip_pkg::*;
#(
    parameter int unsigned width_p = bsg_manycore_packet_width(hb_addr_width_gp, hb_data_width_gp,
                                                               hb_x_cord_width_gp, hb_y_cord_width_gp),
    parameter int unsigned credit_p              = link_credit_gp,
    parameter int unsigned lg_token_decimation_p = link_lg_token_decimation_gp
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          v_i,
    input  logic [width_p-1:0]            data_i,
    output logic                          ready_and_o,
    output logic                          link_v_o,
    output logic [width_p-1:0]            link_data_o,
    input  logic                          link_token_i,
    output logic [$clog2(credit_p+1)-1:0] credits_o,
    output logic                          credit_err_o
);

    localparam int unsigned cw = $clog2(credit_p + 1);

    logic                 send;
    logic [cw-1:0]        credits_next;
    logic                 overflow;
    link_tx_state_e       state_r, state_n;
    logic                 ready_n;
    logic                 link_v_n;
    logic [width_p-1:0]   link_data_n;

    assign send = v_i & ready_and_o;

    bsg_chip_link_credit_counter #(
        .credit_p              (credit_p),
        .lg_token_decimation_p (lg_token_decimation_p)
    ) counter (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .send_i         (send),
        .token_i        (link_token_i),
        .credits_o      (credits_o),
        .credits_next_c (credits_next),
        .overflow_c     (overflow)
    );

    // Next state and next registered outputs; ready is registered from the next credit count
    always_comb begin
        state_n     = state_r;
        ready_n     = (credits_next != '0);
        link_v_n    = send;
        link_data_n = send ? data_i : link_data_o;
        unique case (state_r)
            e_stall: begin
                if (link_token_i) state_n = e_idle;
            end
            default: begin
                if (credits_next == '0) state_n = e_stall;
                else if (send)          state_n = e_send;
                else                    state_n = e_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r     <= e_idle;
            ready_and_o <= 1'(credit_p != 0);
            link_v_o    <= 1'b0;
            link_data_o <= '0;
        end else begin
            state_r     <= state_n;
            ready_and_o <= ready_n;
            link_v_o    <= link_v_n;
            link_data_o <= link_data_n;
        end
    end

`ifdef BSG_CHIP_LINK_CREDIT_CHECK_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credit_err_o <= 1'b0;
        end else if (overflow) begin
            credit_err_o <= 1'b1;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i) !overflow);
    a_no_send_at_zero: assert property (@(posedge clk_i) disable iff (reset_i)
                                        !(send && (credits_o == '0)));
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign credit_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_chip_mc_link_credit_tx.sv
// Scoreboard bench for bsg_chip_mc_link_credit_tx with an independent credit reference model.
module tb_bsg_chip_mc_link_credit_tx;

    localparam int unsigned W      = 16;
    localparam int          CREDIT = 16;
    localparam int          LG     = 2;
    localparam int          TOKENS = 1 << LG;
    localparam int unsigned CW     = $clog2(CREDIT + 1);

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          v_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          ready_and_o;
    logic          link_v_o;
    logic [W-1:0]  link_data_o;
    logic          link_token_i = 1'b0;
    logic [CW-1:0] credits_o;
    logic          credit_err_o;

    int checks = 0;
    int errors = 0;
    int mc     = CREDIT;
    int pulses = 0;
    logic [W-1:0] sb[$];

    bsg_chip_mc_link_credit_tx #(
        .width_p               (W),
        .credit_p              (CREDIT),
        .lg_token_decimation_p (LG)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .v_i          (v_i),
        .data_i       (data_i),
        .ready_and_o  (ready_and_o),
        .link_v_o     (link_v_o),
        .link_data_o  (link_data_o),
        .link_token_i (link_token_i),
        .credits_o    (credits_o),
        .credit_err_o (credit_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, predict with the reference model, compare after the posedge
    task automatic step(input logic v, input logic [W-1:0] d, input logic tok);
        logic snd;
        int   nxt;
        @(negedge clk);
        v_i          = v;
        data_i       = d;
        link_token_i = tok;
        check("ready", 32'(ready_and_o), 32'(mc != 0));
        snd = v && (mc != 0);
        if (snd) sb.push_back(d);
        nxt = mc - (snd ? 1 : 0) + (tok ? TOKENS : 0);
        if (nxt > CREDIT) nxt = CREDIT;
        @(posedge clk);
        #1;
        mc = nxt;
        check("credits", 32'(credits_o), 32'(mc));
        check("link_v", 32'(link_v_o), 32'(snd));
        check("credit_err", 32'(credit_err_o), 32'd0);
        if (link_v_o) begin
            pulses++;
            if (sb.size() == 0) check("unexpected_pkt", 32'(link_data_o), 32'hDEAD);
            else check("data", 32'(link_data_o), 32'(sb.pop_front()));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_link_v", 32'(link_v_o), 32'd0);
        check("rst_data", 32'(link_data_o), 32'd0);
        check("rst_credits", 32'(credits_o), 32'(CREDIT));
        check("rst_err", 32'(credit_err_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;

        // Continuous traffic drains all credits in order
        pulses = 0;
        for (int i = 0; i < 20; i++) step(1'b1, W'(16'h100 + i), 1'b0);
        check("burst_pulses", 32'(pulses), 32'(CREDIT));
        check("burst_ready", 32'(ready_and_o), 32'd0);
        check("burst_credits", 32'(credits_o), 32'd0);

        // One token from zero buys TOKENS packets
        step(1'b0, '0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 6; i++) step(1'b1, W'(16'h200 + i), 1'b0);
        check("token_pulses", 32'(pulses), 32'(TOKENS));
        check("token_stall", 32'(credits_o), 32'd0);

        // Credits 1 with simultaneous send and token
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, W'(16'h300 + i), 1'b0);
        check("one_credit", 32'(credits_o), 32'd1);
        step(1'b1, W'(16'h3FF), 1'b1);
        check("send_and_token", 32'(credits_o), 32'(TOKENS));

        // Credits 15 plus a token saturates
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        step(1'b1, W'(16'h400), 1'b0);
        check("fifteen", 32'(credits_o), 32'(CREDIT - 1));
        step(1'b0, '0, 1'b1);
        check("saturate", 32'(credits_o), 32'(CREDIT));
        check("sat_err", 32'(credit_err_o), 32'd0);

        // Reset mid-burst discards the packet accepted that cycle
        step(1'b1, W'(16'h500), 1'b0);
        step(1'b1, W'(16'h501), 1'b0);
        @(negedge clk);
        v_i    = 1'b1;
        data_i = W'(16'hA5);
        #2;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        mc = CREDIT;
        check("midrst_link_v", 32'(link_v_o), 32'd0);
        check("midrst_credits", 32'(credits_o), 32'(CREDIT));
        check("midrst_ready", 32'(ready_and_o), 32'd1);
        @(negedge clk);
        reset_i = 1'b0;
        v_i     = 1'b0;
        step(1'b0, '0, 1'b0);
        check("no_a5", 32'(link_data_o == W'(16'hA5)), 32'd0);

        // Random traffic against the reference model
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 5) == 0));
        step(1'b0, '0, 1'b0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("final_err", 32'(credit_err_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_chip_mc_link_credit_tx.md
BSG_CHIP_MC_LINK_CREDIT_TX -- requirements
Module: bsg_chip_mc_link_credit_tx

Interface
REQ-001 SHALL have parameter width_p, default `bsg_manycore_packet_width(hb_addr_width_gp,hb_data_width_gp,hb_x_cord_width_gp,hb_y_cord_width_gp)`; link payload width.
REQ-002 SHALL have parameter credit_p, default 16; receiver buffer depth, which is also the reset credit count.
REQ-003 SHALL have parameter lg_token_decimation_p, default 2; each token pulse returns 2**lg_token_decimation_p credits.
REQ-004 SHALL have port clk_i, input, 1 bit; the single clock.
REQ-005 SHALL have port reset_i, input, 1 bit; reset is asynchronous and active-high.
REQ-006 SHALL have port v_i, input, 1 bit; upstream packet valid.
REQ-007 SHALL have port data_i, input, width_p bits; upstream packet.
REQ-008 SHALL have port ready_and_o, output, 1 bit; the block accepts a packet this cycle.
REQ-009 SHALL have port link_v_o, output, 1 bit; link valid toward the manycore pod row link input.
REQ-010 SHALL have port link_data_o, output, width_p bits; link payload.
REQ-011 SHALL have port link_token_i, input, 1 bit; single-cycle credit-return pulse, already synchronous to clk_i.
REQ-012 SHALL have port credits_o, output, $clog2(credit_p+1) bits; current credit count.
REQ-013 SHALL have port credit_err_o, output, 1 bit; sticky credit overflow/underflow flag.

Function
REQ-014 ready_and_o SHALL equal (credits_r != 0), with no combinational dependence on v_i or link_token_i.
REQ-015 A send SHALL occur when v_i & ready_and_o.
REQ-016 On a send, link_v_o SHALL be 1 and link_data_o SHALL equal data_i on the next cycle (latency 1, registered).
REQ-017 link_v_o SHALL be 0 in every cycle that does not follow a send.
REQ-018 link_data_o SHALL hold its last value when link_v_o is 0.
REQ-019 The credit count SHALL update as credits_next = credits_r - send + (link_token_i ? 2**lg_token_decimation_p : 0), computed at full width before any saturation.
REQ-020 A simultaneous send and token in the same cycle SHALL both be applied in the same cycle.
REQ-021 When the full-width credits_next exceeds credit_p, credits_r SHALL saturate at credit_p (overflow).
REQ-022 At zero credits, ready_and_o SHALL be 0, so no send is possible; a token arriving in the same cycle SHALL make ready_and_o 1 on the next cycle.
REQ-023 State machine: IDLE (credits > 0, no send last cycle), SEND (link_v_o=1), STALL (credits == 0).
REQ-024 Transitions: IDLE→SEND on send; SEND→SEND on back-to-back send; SEND/IDLE→STALL when credits reach 0 and no token; STALL→IDLE on token.
REQ-025 Throughput SHALL be one packet per cycle while credits > 0.
REQ-026 credits_o SHALL reflect credits_r (registered value).

Reset
REQ-027 On reset_i assertion, asynchronously: credits_r=credit_p, link_v_o=0, link_data_o='0, credit_err_o=0, state=IDLE.
REQ-028 A packet accepted in the cycle reset asserts SHALL be discarded, with no link_v_o pulse after reset.
REQ-029 Tokens arriving while reset_i=1 SHALL be ignored.

Configuration
REQ-030 With BSG_CHIP_LINK_CREDIT_CHECK_EN defined: credit_err_o SHALL set on overflow (REQ-021) and stay set until reset; simulation assertions SHALL fire on overflow and on send with zero credits.
REQ-031 Without BSG_CHIP_LINK_CREDIT_CHECK_EN: credit_err_o SHALL be tied 0, no assertions SHALL be present, and saturation SHALL still apply.

Structure
REQ-032 Default credit_p and lg_token_decimation_p SHALL be constants in bsg_chip_pkg, shared with the receive-side token generator.
REQ-033 The credit arithmetic and saturation SHALL live in sub-module bsg_chip_link_credit_counter.
REQ-034 The top level SHALL contain the output register and state machine.

Verification
REQ-035 Reset then v_i=1 continuous, no tokens, credit_p=16: exactly 16 link_v_o pulses, data in order, then ready_and_o=0 and credits_o=0.
REQ-036 From credits 0, one token pulse, lg=2: credits_o=4 next cycle; 4 further packets sent; stall again.
REQ-037 credits 1, send and token same cycle, lg=2: credits_o=4 next cycle.
REQ-038 credits 15, token, lg=2 (credit_p=16): credits_o=16, credit_err_o=1 with the macro and 0 without.
REQ-039 Reset asserted mid-burst, with data_i=0xA5 accepted that cycle: link_v_o=0 after reset, credits_o=16, no 0xA5 emitted.
REQ-040 Random v_i/token traffic against a reference credit model: packet order preserved, no send at zero credits, credit_err_o stays 0.
